// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter with a one-entry holding register
// so that queued frames go out back-to-back with no idle gap.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clkx16,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);
    localparam int TW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state;
    logic [TW-1:0]        tick;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift, hold, next_data;
    logic                 hold_full, par, accept, last, frame_end, launch;
    assign ready = !hold_full;
    always_comb begin
        accept    = load && !hold_full;
        last      = tick == TW'(OVERSAMPLE - 1);
        frame_end = state == STOP && last && bit_idx == 3'(STOP_BITS - 1);
        // a frame starts either from idle or seamlessly off the final stop tick
        launch    = (accept && state == IDLE) || (frame_end && (hold_full || accept));
        next_data = hold_full ? hold : data;
    end
    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            par       <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            hold_full <= !launch && (hold_full || accept);
            if (accept && !launch)
                hold <= data;
            tick <= (launch || last || state == IDLE) ? '0 : tick + TW'(1);
            if (launch) begin
                state   <= START;
                shift   <= next_data;
                par     <= ^next_data ^ (PARITY_ODD != 0);
                bit_idx <= '0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end else if (last) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                            tx      <= (PARITY_EN != 0) ? par : 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        if (frame_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter paired with the board's UART receiver. It shares the receiver's 16x-oversampled baud clock from the clock generator and frame format (start bit, LSB-first data, optional parity, stop bits), and drives the board's TX pin. A one-entry holding register lets the host queue the next byte while the current frame is on the line, so frames go out back-to-back with no idle gap.

## Interface
- DATA_BITS, 8: data bits per frame (5..8).
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: parity sense when PARITY_EN=1 (0 = even, 1 = odd).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- OVERSAMPLE, 16: clkx16 cycles per bit.
- clkx16  in  1  16x baud clock. This is the only clock.
- reset  in  1  asynchronous, active-high.
- data  in  DATA_BITS  byte to send. Sampled only on the accept edge.
- load  in  1  write strobe. A write is accepted on a rising edge where load && ready.
- ready  out  1  holding register empty. A write will be accepted.
- busy  out  1  a frame is in progress on tx.
- tx  out  1  serial line. Idles high. Registered output.

## Operation
- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx = shift[0], LSB first.
  - PARITY: tx = parity bit. Present only if PARITY_EN=1.
  - STOP: tx=1, for STOP_BITS bits.
- Counters:
  - tick counts 0..OVERSAMPLE-1 within each bit.
  - bit_idx counts data bits and stop bits.
  - Each bit lasts exactly OVERSAMPLE cycles.
- Frame length F = OVERSAMPLE*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles. F = 160 for 8N1.
- Parity is computed over the captured data:
  - even: XOR of all data bits.
  - odd: inverted XOR of all data bits.
- Accepting a write in IDLE: the data goes straight into the shifter and the state becomes START. ready stays 1.
- Accepting a write during a frame: the data goes into the holding register and ready becomes 0.
- Last cycle of the final stop bit:
  - If the holding register is full, its data moves to the shifter, the state becomes START, and ready becomes 1.
  - If the holding register is empty but load && ready on that same edge, the new data goes directly to the shifter and the state becomes START.
  - Otherwise the state becomes IDLE and busy becomes 0.
- load while ready=0 is ignored. The data is dropped without an error flag, and the held byte is unchanged.
- Changes on data after the accept edge have no effect on the frame.

## Timing
- Reset values: tx=1, busy=0, ready=1, state IDLE, holding register empty, counters 0. Reset takes effect asynchronously.
- Reset mid-frame: the frame is aborted and tx returns to 1 immediately. Any held byte is discarded.
- Latency: if load is accepted at edge E while IDLE, tx=0 and busy=1 are visible after E. The start bit spans edges E..E+OVERSAMPLE.
- Bit k (k=0 is the start bit) occupies cycles E+k*OVERSAMPLE through E+(k+1)*OVERSAMPLE-1.
- busy falls at edge E+F when nothing is queued.
- Back-to-back frames: the next start bit begins at edge E+F exactly. tx stays 1 only during the stop bits, with no extra idle cycle.
- A write accepted mid-frame sets ready=0 after the accept edge. ready returns to 1 on the edge that launches the held byte.

## Test plan
- 8N1, reset released, load 0x55 at edge 0:
  - tx sequence per 16 cycles is 0,1,0,1,0,1,0,1,0,1.
  - busy=1 for edges 0..159, then busy=0 and tx=1.
- Back-to-back: load 0xA5 in IDLE, then load 0x3C at cycle 20:
  - ready=0 from cycle 21 until cycle 160.
  - The second start bit begins at cycle 160.
  - 320 contiguous frame cycles with no gap.
- Overflow: with one byte in flight and one held, pulse load with 0xFF.
  - The write is ignored.
  - The held byte is transmitted unchanged and no third frame appears.
- Parity: PARITY_EN=1, PARITY_ODD=1, send 0x07.
  - The parity bit is 0 (three ones, odd sense).
  - F=176.
  - With PARITY_ODD=0 the parity bit is 1.
- Reset mid-frame: assert reset at cycle 70 of a frame with a byte held.
  - tx=1, busy=0, ready=1 immediately.
  - No frame after release until a new load.
- STOP_BITS=2, send 0x00:
  - tx is low for 144 cycles, then high for 32 cycles.
  - busy falls at cycle 176.
